// File: rtl/bounce_sprites.sv
// bounce_sprites: boxes bounce off the screen edges and step colour on each hit; a per-frame FSM updates them and a renderer draws the committed copy
module bounce_sprites #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_BOXES     = 4,
  parameter int BOX_W         = 100,
  parameter int BOX_H         = 100,
  parameter int SPEED         = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       frame,
  input  logic                              visible,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]   position_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]  position_y,
  output logic [3:0]                        r,
  output logic [3:0]                        g,
  output logic [3:0]                        b,
  output logic                              busy,
  output logic                              corner_hit
);
  localparam int XW = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
  localparam int IW = NUM_BOXES > 1 ? $clog2(NUM_BOXES) : 1;
  localparam int VY = SPEED / 2 < 1 ? 1 : SPEED / 2;
  localparam logic signed [XW-1:0] XMAX = XW'(SCREEN_WIDTH - BOX_W);
  localparam logic signed [YW-1:0] YMAX = YW'(SCREEN_HEIGHT - BOX_H);
  localparam logic signed [XW-1:0] BW = XW'(BOX_W);
  localparam logic signed [YW-1:0] BH = YW'(BOX_H);
  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;
  state_t state;
  logic signed [XW-1:0] x [NUM_BOXES];
  logic signed [XW-1:0] vx [NUM_BOXES];
  logic signed [XW-1:0] dx [NUM_BOXES];
  logic signed [YW-1:0] y [NUM_BOXES];
  logic signed [YW-1:0] vy [NUM_BOXES];
  logic signed [YW-1:0] dy [NUM_BOXES];
  logic [2:0] col [NUM_BOXES];
  logic [2:0] dcol [NUM_BOXES];
  logic [31:0] frame_prev;
  logic pending;
  logic [IW-1:0] idx;
  logic signed [XW-1:0] tx;
  logic signed [YW-1:0] ty;
  logic hx, hy;
  logic [2:0] next_col;
  logic signed [XW-1:0] px;
  logic signed [YW-1:0] py;
  logic hit;
  logic [2:0] c;
  always_comb begin
    tx = x[idx] + vx[idx];
    ty = y[idx] + vy[idx];
    hx = tx[XW-1] || tx > XMAX;
    hy = ty[YW-1] || ty > YMAX;
    next_col = col[idx] == 3'd7 ? 3'd1 : col[idx] + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      corner_hit <= 1'b0;
      frame_prev <= '0;
      pending <= 1'b0;
      idx <= '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
        x[i] <= XW'(50 + 32 * i);
        y[i] <= YW'(50 + 24 * i);
        dx[i] <= XW'(50 + 32 * i);
        dy[i] <= YW'(50 + 24 * i);
        vx[i] <= i % 2 == 1 ? -XW'(SPEED) : XW'(SPEED);
        vy[i] <= i % 2 == 1 ? -YW'(VY) : YW'(VY);
        col[i] <= 3'(i % 7 + 1);
        dcol[i] <= 3'(i % 7 + 1);
      end
    end else begin
      corner_hit <= 1'b0;
      case (state)
        IDLE: if (frame != frame_prev || pending) begin
          frame_prev <= frame;
          pending <= 1'b0;
          idx <= '0;
          busy <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: begin
          x[idx] <= hx ? (tx[XW-1] ? '0 : XMAX) : tx;
          y[idx] <= hy ? (ty[YW-1] ? '0 : YMAX) : ty;
          vx[idx] <= hx ? -vx[idx] : vx[idx];
          vy[idx] <= hy ? -vy[idx] : vy[idx];
          col[idx] <= hx || hy ? next_col : col[idx];
          corner_hit <= hx && hy;
          if (idx == IW'(NUM_BOXES - 1)) state <= COMMIT;
          else idx <= idx + 1'b1;
        end
        COMMIT: begin
          dx <= x;
          dy <= y;
          dcol <= col;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // frame changes seen mid-update collapse into a single follow-up update
      if (state != IDLE && frame != frame_prev) begin
        pending <= 1'b1;
        frame_prev <= frame;
      end
    end
  end
  always_comb begin
    px = $signed({1'b0, position_x});
    py = $signed({1'b0, position_y});
    hit = 1'b0;
    c = 3'd0;
    for (int j = NUM_BOXES - 1; j >= 0; j--)
      if (dx[j] <= px && px < dx[j] + BW && dy[j] <= py && py < dy[j] + BH) begin
        hit = 1'b1;
        c = dcol[j];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) {r, g, b} <= '0;
    else {r, g, b} <= visible && hit ? {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}} : 12'h000;
  end
endmodule

// File: tb/tb_bounce_sprites.sv
// tb_bounce_sprites: random frame/pixel stimulus checked against a behavioural model of the bouncing boxes
module tb_bounce_sprites;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] frame = '0;
  logic visible = 1'b0;
  logic [9:0] position_x = '0;
  logic [8:0] position_y = '0;
  logic [3:0] r, g, b;
  logic busy, corner_hit;
  int errors = 0;
  int checks = 0;
  int mx[NB], my[NB], mvx[NB], mvy[NB], mc[NB], dx[NB], dy[NB], dc[NB];

  always #5 clk = ~clk;

  bounce_sprites dut (
    .clk(clk), .rst(rst), .frame(frame), .visible(visible),
    .position_x(position_x), .position_y(position_y),
    .r(r), .g(g), .b(b), .busy(busy), .corner_hit(corner_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i] = 50 + 32 * i;
      my[i] = 50 + 24 * i;
      mvx[i] = i % 2 ? -2 : 2;
      mvy[i] = i % 2 ? -1 : 1;
      mc[i] = i % 7 + 1;
      dx[i] = mx[i];
      dy[i] = my[i];
      dc[i] = mc[i];
    end
  endfunction

  function automatic int bounce(inout int p, inout int v, input int pmax);
    int t = p + v;
    if (t < 0 || t > pmax) begin
      p = t < 0 ? 0 : pmax;
      v = -v;
      return 1;
    end
    p = t;
    return 0;
  endfunction

  function automatic int model_update();
    int corners = 0;
    for (int i = 0; i < NB; i++) begin
      int hx = bounce(mx[i], mvx[i], 540);
      int hy = bounce(my[i], mvy[i], 380);
      if (hx + hy > 0) mc[i] = mc[i] == 7 ? 1 : mc[i] + 1;
      if (hx + hy == 2) corners++;
    end
    dx = mx;
    dy = my;
    dc = mc;
    return corners;
  endfunction

  function automatic logic [11:0] model_pix(input int x, input int y, input bit vis);
    for (int j = 0; j < NB; j++)
      if (x >= dx[j] && x < dx[j] + 100 && y >= dy[j] && y < dy[j] + 100) begin
        int c = dc[j];
        return vis ? {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}} : 12'h000;
      end
    return 12'h000;
  endfunction

  task automatic do_frame(input int pokes);
    int nb = 0, nc = 0, ec;
    @(negedge clk);
    frame = frame + 1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      nb += int'(busy);
      nc += int'(corner_hit);
      if (cyc < pokes) frame = frame + 1;
    end
    ec = model_update();
    if (pokes > 0) ec += model_update();
    check("busy_cycles", 32'(nb), pokes > 0 ? 32'd10 : 32'd5);
    check("corner_pulses", 32'(nc), 32'(ec));
  endtask

  task automatic pix(input string tag, input int x, input int y, input bit vis);
    int cx = x < 0 ? 0 : (x > 639 ? 639 : x);
    int cy = y < 0 ? 0 : (y > 479 ? 479 : y);
    @(negedge clk);
    position_x = 10'(cx);
    position_y = 9'(cy);
    visible = vis;
    @(negedge clk);
    check(tag, 32'({r, g, b}), 32'(model_pix(cx, cy, vis)));
  endtask

  task automatic render_sweep();
    int k = $urandom_range(0, NB - 1);
    pix("edge_tl", dx[k], dy[k], 1'b1);
    pix("edge_br", dx[k] + 99, dy[k] + 99, 1'b1);
    pix("edge_left_out", dx[k] - 1, dy[k], 1'b1);
    pix("edge_right_out", dx[k] + 100, dy[k] + 50, 1'b1);
    pix("edge_below_out", dx[k] + 50, dy[k] + 100, 1'b1);
    for (int i = 0; i < 4; i++)
      pix("rand_pix", $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7) != 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'({r, g, b}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    model_reset();
    pix("reset_box0", 50, 50, 1'b1);
    do_frame(0);
    pix("f1_box0_corner", 52, 51, 1'b1);
    check("f1_box0_const", 32'({r, g, b}), 32'h00F);
    pix("f1_left_of_box0", 51, 51, 1'b1);
    check("f1_empty_const", 32'({r, g, b}), 32'h000);
    pix("f1_box1_corner", 179, 172, 1'b1);
    check("f1_box1_const", 32'({r, g, b}), 32'h0F0);
    pix("f1_invisible", 52, 51, 1'b0);
    check("f1_invisible_const", 32'({r, g, b}), 32'h000);
    do_frame(3);
    for (int f = 0; f < 600; f++) begin
      do_frame($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
      if (f % 10 == 0) render_sweep();
    end
    // reset lands while box 2 is being processed
    @(negedge clk);
    frame = frame + 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_rgb", 32'({r, g, b}), 32'h0);
    rst = 1'b0;
    frame = '0;
    model_reset();
    pix("midrst_box0", 50, 50, 1'b1);
    pix("midrst_box3", 146, 221, 1'b1);
    render_sweep();
    do_frame(0);
    render_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
